// File: rtl/block_config_loader.sv
// Serial-to-parallel config loader: MSB-first shift, commit strobes the held word to the latch block.
// Latency: 1 cycle per bit, comb_set registered one cycle after commit in FULL; no backpressure (cfg_en gated only by state).
module block_config_loader #(
   parameter int ADDR_BITS = 4,
   parameter int MEM_SIZE  = 2**ADDR_BITS,
   parameter int CNT_BITS  = $clog2(MEM_SIZE+1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_en,
   input  logic                cfg_in,
   input  logic                cfg_clear,
   input  logic                commit,
   output logic                cfg_out,
   output logic [MEM_SIZE-1:0] config_out,
   output logic                comb_set,
   output logic                full,
   output logic                err,
   output logic [CNT_BITS-1:0] bit_count
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FULL, S_COMMIT} state_t;

   localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MEM_SIZE);

   state_t              state, state_nxt;
   logic [MEM_SIZE-1:0] sreg;
   logic                shift_acc;
   logic                err_set;
   logic                err_clr;
   logic                cnt_clr;

   // Priority: clear > commit > shift; COMMIT ignores every input for its single cycle.
   always_comb begin
      state_nxt = state;
      shift_acc = 1'b0;
      err_set   = 1'b0;
      err_clr   = 1'b0;
      cnt_clr   = 1'b0;
      case (state)
         S_COMMIT: begin
            state_nxt = S_IDLE;
            cnt_clr   = 1'b1;
            err_clr   = 1'b1;
         end
         default: begin
            if (cfg_clear) begin
               state_nxt = S_IDLE;
               cnt_clr   = 1'b1;
            end else if (commit) begin
               if (state == S_FULL) state_nxt = S_COMMIT;
               else                 err_set   = 1'b1;
            end else if (cfg_en) begin
               shift_acc = 1'b1;
               if (state == S_FULL)
                  err_set = 1'b1;
               else if (bit_count == CNT_MAX - CNT_BITS'(1))
                  state_nxt = S_FULL;
               else
                  state_nxt = S_SHIFT;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         sreg      <= '0;
         bit_count <= '0;
         comb_set  <= 1'b0;
         err       <= 1'b0;
      end else begin
         state    <= state_nxt;
         comb_set <= (state_nxt == S_COMMIT);
         if (shift_acc)
            sreg <= {sreg[MEM_SIZE-2:0], cfg_in};
         if (cnt_clr)
            bit_count <= '0;
         else if (shift_acc && bit_count != CNT_MAX)
            bit_count <= bit_count + CNT_BITS'(1);
         if (err_clr)
            err <= 1'b0;
         else if (err_set)
            err <= 1'b1;
      end
   end

   assign cfg_out    = sreg[MEM_SIZE-1];
   assign config_out = sreg;
   assign full       = (bit_count == CNT_MAX);

endmodule

// File: tb/tb_block_config_loader.sv
// Bench for block_config_loader: directed scenarios plus random op stream against a count-based model.
module tb_block_config_loader;

   localparam int MS = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_en = 1'b0, cfg_in = 1'b0, cfg_clear = 1'b0, commit = 1'b0;
   logic          cfg_out, comb_set, full, err;
   logic [MS-1:0] config_out;
   logic [4:0]    bit_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: word held, bits received, sticky error, strobe pending
   logic [MS-1:0] m_sreg;
   int            m_cnt;
   bit            m_err;
   bit            m_strobe;

   block_config_loader #(.ADDR_BITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_in(cfg_in),
      .cfg_clear(cfg_clear), .commit(commit), .cfg_out(cfg_out),
      .config_out(config_out), .comb_set(comb_set), .full(full),
      .err(err), .bit_count(bit_count)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_sreg = '0; m_cnt = 0; m_err = 1'b0; m_strobe = 1'b0;
   endtask

   task automatic model_step(input bit en, input bit in, input bit clr, input bit cmt);
      if (m_strobe) begin
         m_strobe = 1'b0; m_cnt = 0; m_err = 1'b0;
      end else if (clr) begin
         m_cnt = 0;
      end else if (cmt) begin
         if (m_cnt == MS) m_strobe = 1'b1;
         else             m_err = 1'b1;
      end else if (en) begin
         m_sreg = {m_sreg[MS-2:0], in};
         if (m_cnt == MS) m_err = 1'b1;
         else             m_cnt++;
      end
   endtask

   task automatic cyc(input bit en, input bit in, input bit clr, input bit cmt);
      cfg_en = en; cfg_in = in; cfg_clear = clr; commit = cmt;
      @(posedge clk);
      model_step(en, in, clr, cmt);
      #1;
      cfg_en = 1'b0; cfg_in = 1'b0; cfg_clear = 1'b0; commit = 1'b0;
   endtask

   task automatic shift_word(input logic [MS-1:0] w);
      for (int i = MS-1; i >= 0; i--) cyc(1'b1, w[i], 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({cfg_out, config_out, comb_set, full, err, bit_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%h exp=0", {cfg_out, config_out, comb_set, full, err, bit_count});
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (err !== 1'b1 || comb_set !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_commit err=%b comb_set=%b exp err=1 comb_set=0", err, comb_set);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (comb_set !== 1'b0 || bit_count !== 5'd0) begin
         n_fail++;
         $display("FAIL idle_commit_after comb_set=%b count=%0d exp 0/0", comb_set, bit_count);
      end
   endtask

   task automatic test_load();
      logic [MS-1:0] w = 16'hA5C3;
      for (int i = MS-1; i >= 1; i--) cyc(1'b1, w[i], 1'b0, 1'b0);
      n_checks++;
      if (full !== 1'b0 || bit_count !== 5'd15) begin
         n_fail++;
         $display("FAIL load_15 full=%b count=%0d exp 0/15", full, bit_count);
      end
      cyc(1'b1, w[0], 1'b0, 1'b0);
      n_checks++;
      if (full !== 1'b1 || bit_count !== 5'd16 || config_out !== w) begin
         n_fail++;
         $display("FAIL load_16 full=%b count=%0d cfg=%h exp 1/16/%h", full, bit_count, config_out, w);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (comb_set !== 1'b1 || config_out !== w) begin
         n_fail++;
         $display("FAIL load_strobe comb_set=%b cfg=%h exp 1/%h", comb_set, config_out, w);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (comb_set !== 1'b0 || bit_count !== 5'd0 || err !== 1'b0 || config_out !== w) begin
         n_fail++;
         $display("FAIL load_after comb_set=%b count=%0d err=%b cfg=%h exp 0/0/0/%h",
                  comb_set, bit_count, err, config_out, w);
      end
   endtask

   task automatic test_clear_reload();
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (bit_count !== 5'd0 || full !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_count count=%0d full=%b exp 0/0", bit_count, full);
      end
      shift_word(16'h1234);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (comb_set !== 1'b1 || config_out !== 16'h1234 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_reload comb_set=%b cfg=%h err=%b exp 1/1234/0", comb_set, config_out, err);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_overflow();
      logic [MS-1:0] exp_w [3] = '{16'hFFFE, 16'hFFFC, 16'hFFF8};
      shift_word(16'hFFFF);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0);
         n_checks++;
         if (cfg_out !== 1'b1 || err !== 1'b1 || bit_count !== 5'd16 || config_out !== exp_w[i]) begin
            n_fail++;
            $display("FAIL overflow_%0d cfg_out=%b err=%b count=%0d cfg=%h exp 1/1/16/%h",
                     i, cfg_out, err, bit_count, config_out, exp_w[i]);
         end
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (comb_set !== 1'b1 || config_out !== 16'hFFF8) begin
         n_fail++;
         $display("FAIL overflow_strobe comb_set=%b cfg=%h exp 1/fff8", comb_set, config_out);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (err !== 1'b0 || comb_set !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_err_clear err=%b comb_set=%b exp 0/0", err, comb_set);
      end
   endtask

   task automatic test_commit_priority();
      logic [MS-1:0] w = MS'($urandom);
      shift_word(w);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (comb_set !== 1'b1 || config_out !== w || err !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_strobe comb_set=%b cfg=%h err=%b exp 1/%h/0", comb_set, config_out, err, w);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (comb_set !== 1'b0 || config_out !== w || bit_count !== 5'd0) begin
         n_fail++;
         $display("FAIL prio_after comb_set=%b cfg=%h count=%0d exp 0/%h/0", comb_set, config_out, bit_count, w);
      end
   endtask

   task automatic test_reset_in_commit();
      shift_word(16'hBEEF);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (comb_set !== 1'b0 || config_out !== '0) begin
         n_fail++;
         $display("FAIL rst_commit_async comb_set=%b cfg=%h exp 0/0", comb_set, config_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (comb_set !== 1'b0 || bit_count !== 5'd0 || full !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_commit_after comb_set=%b count=%0d full=%b err=%b exp 0/0/0/0",
                  comb_set, bit_count, full, err);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (bit_count !== 5'd1 || config_out !== 16'h0001) begin
         n_fail++;
         $display("FAIL rst_commit_shift count=%0d cfg=%h exp 1/0001", bit_count, config_out);
      end
   endtask

   task automatic test_random();
      int r;
      for (int c = 0; c < 600; c++) begin
         r = $urandom_range(0, 99);
         if (r < 72)      cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
         else if (r < 84) cyc(1'b0, 1'b0, 1'b0, 1'b1);
         else if (r < 88) cyc(1'b0, 1'b0, 1'b1, 1'b0);
         else if (r < 92) cyc(1'b1, 1'($urandom), 1'b0, 1'b1);
         else             cyc(1'b0, 1'b0, 1'b0, 1'b0);
         n_checks++;
         if (config_out !== m_sreg || cfg_out !== m_sreg[MS-1] || comb_set !== m_strobe ||
             full !== (m_cnt == MS) || err !== m_err || bit_count !== 5'(m_cnt)) begin
            n_fail++;
            $display("FAIL rnd_%0d cfg=%h strb=%b full=%b err=%b cnt=%0d exp cfg=%h strb=%b full=%b err=%b cnt=%0d",
                     c, config_out, comb_set, full, err, bit_count,
                     m_sreg, m_strobe, (m_cnt == MS), m_err, m_cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_clear_reload();
      test_overflow();
      test_commit_priority();
      test_reset_in_commit();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
